freq_gate_controller: RTL and testbench

Gating and result-capture stage around the N-digit BCD pulse counter in the frequency-counter datapath.
- Synchronises the external measured signal and turns each rising edge into a one-cycle count-enable pulse.
- Clears the counter, opens a fixed gate window, then latches the counter's BCD digits and overflow status for the OLED display path.
- Repeats the measurement continuously.

---
 rtl/freq_gate_controller.sv | 143 ++++++++++++++
 tb/tb_freq_gate_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_controller.sv
// freq_gate_controller: gate window and result capture around the BCD counter.
// Optional leading-zero blanking on latch: FREQ_GATE_BLANK_LEADING_ZEROS_EN.
module freq_gate_controller #(
  parameter int DIGITS_NUM  = 6,
  parameter int GATE_CYCLES = 12000000
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    signal_in,
  output logic                    counter_reset_out,
  output logic                    counter_enable_out,
  input  logic [4*DIGITS_NUM-1:0] digits_in,
  input  logic                    carry_in,
  output logic [4*DIGITS_NUM-1:0] result_out,
  output logic                    overflow_out,
  output logic                    result_valid_out,
  output logic                    gate_active_out
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_GATE,
    S_SETTLE,
    S_LATCH
  } state_t;

  state_t                  r_state;
  logic [GW-1:0]           r_gate_cnt;
  logic                    r_ovf_trk;
  logic                    r_cnt_rst;
  logic                    r_gate_act;
  logic [4*DIGITS_NUM-1:0] r_result;
  logic                    r_ovf;
  logic                    r_valid;

  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_sync3;

  logic                    w_rise;
  logic                    w_ovf_hit;
  logic [4*DIGITS_NUM-1:0] w_latch_val;

  // Two-flop synchroniser plus one flop of history for edge detection
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= signal_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync3;

  // Only rises inside the gate reach the counter; others are dropped
  assign counter_enable_out = w_rise & (r_state == S_GATE);

  assign w_ovf_hit = carry_in & counter_enable_out;

  // Value captured at LATCH, optionally with leading zeros blanked
`ifdef FREQ_GATE_BLANK_LEADING_ZEROS_EN
  logic w_blank_run;

  always_comb begin
    w_latch_val = digits_in;
    w_blank_run = 1'b1;
    for (int i = DIGITS_NUM - 1; i > 0; i--) begin
      if (w_blank_run && (digits_in[4*i +: 4] == 4'd0)) begin
        w_latch_val[4*i +: 4] = 4'hF;
      end else begin
        w_blank_run = 1'b0;
      end
    end
  end
`else
  always_comb begin
    w_latch_val = digits_in;
  end
`endif

  // Measurement sequencer: CLEAR -> GATE -> SETTLE -> LATCH, repeating
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state    <= S_CLEAR;
      r_gate_cnt <= '0;
      r_ovf_trk  <= 1'b0;
      r_cnt_rst  <= 1'b1;
      r_gate_act <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_CLEAR: begin
          r_state    <= S_GATE;
          r_gate_cnt <= GATE_LOAD;
          r_ovf_trk  <= 1'b0;
          r_cnt_rst  <= 1'b0;
          r_gate_act <= 1'b1;
        end
        S_GATE: begin
          if (w_ovf_hit) begin
            r_ovf_trk <= 1'b1;
          end
          if (r_gate_cnt == '0) begin
            r_state    <= S_SETTLE;
            r_gate_act <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_result  <= w_latch_val;
          r_ovf     <= r_ovf_trk;
          r_valid   <= 1'b1;
          r_cnt_rst <= 1'b1;
          r_state   <= S_CLEAR;
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  assign counter_reset_out = r_cnt_rst;
  assign gate_active_out   = r_gate_act;
  assign result_out        = r_result;
  assign overflow_out      = r_ovf;
  assign result_valid_out  = r_valid;

endmodule

// File: tb/tb_freq_gate_controller.sv
// tb_freq_gate_controller: scoreboard bench, 6-digit and 1-digit instances.
// Shared signal and reset; behavioural BCD counters model the datapath.
module tb_freq_gate_controller;

  localparam int GC  = 100;
  localparam int PER = GC + 3;

  typedef struct {
    logic [23:0] res;
    logic        ovf;
  } exp_t;

  typedef enum int {P_SQ, P_LOW, P_HIGH, P_LATE, P_PULSE, P_TRI} pat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sig;

  logic        crA, enA, carA, ovA, rvA, gaA;
  logic [23:0] digA, resA;
  logic        crB, enB, carB, ovB, rvB, gaB;
  logic [3:0]  digB, resB;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_ref = 0;

  exp_t qA[$];
  exp_t qB[$];

  freq_gate_controller #(.DIGITS_NUM(6), .GATE_CYCLES(GC)) dutA (
    .clk_in(clk), .reset_n_in(rst_n), .signal_in(sig),
    .counter_reset_out(crA), .counter_enable_out(enA),
    .digits_in(digA), .carry_in(carA),
    .result_out(resA), .overflow_out(ovA),
    .result_valid_out(rvA), .gate_active_out(gaA)
  );

  freq_gate_controller #(.DIGITS_NUM(1), .GATE_CYCLES(GC)) dutB (
    .clk_in(clk), .reset_n_in(rst_n), .signal_in(sig),
    .counter_reset_out(crB), .counter_enable_out(enB),
    .digits_in(digB), .carry_in(carB),
    .result_out(resB), .overflow_out(ovB),
    .result_valid_out(rvB), .gate_active_out(gaB)
  );

  function automatic logic [23:0] bcd_inc(input logic [23:0] v, input int nd);
    logic [23:0] r = v;
    logic c = 1'b1;
    for (int i = 0; i < nd; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic all9(input logic [23:0] v, input int nd);
    logic a = 1'b1;
    for (int i = 0; i < nd; i++) begin
      if (v[4*i +: 4] != 4'd9) a = 1'b0;
    end
    return a;
  endfunction

  function automatic logic [23:0] disp6(input logic [23:0] v);
    logic [23:0] r = v;
`ifdef FREQ_GATE_BLANK_LEADING_ZEROS_EN
    for (int i = 5; i > 0; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic logic lvl(input pat_t p, input int s, input int m);
    case (p)
      P_SQ:    return (m % 4) < 2;
      P_LOW:   return 1'b0;
      P_HIGH:  return 1'b1;
      P_LATE:  return m >= 101;
      P_PULSE: return (m == s) || (m == s + 1);
      P_TRI:   return m inside {10, 11, 20, 21, 30, 31};
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural BCD counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (crA) digA <= '0;
    else if (enA) digA <= bcd_inc(digA, 6);
    if (crB) digB <= '0;
    else if (enB) digB <= bcd_inc({20'h0, digB}, 1)[3:0];
  end

  assign carA = enA & all9(digA, 6);
  assign carB = enB & all9({20'h0, digB}, 1);

  task automatic chk(input string nm, input logic [23:0] act,
                     input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a result is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      chk("en_rst_excl", 24'(enA & crA), 24'h0);
      if (rvA || rvB) chk("valid_sync", 24'(rvB), 24'(rvA));
      if (rvA) begin
        chk("valid_spacing", 24'(cyc - last_ref), 24'(PER));
        last_ref = cyc;
        if (qA.size() == 0) begin
          chk("unexpected_validA", 24'(qA.size()), 24'h1);
        end else begin
          e = qA.pop_front();
          chk("resultA", resA, e.res);
          chk("overflowA", 24'(ovA), 24'(e.ovf));
        end
      end
      if (rvB) begin
        if (qB.size() == 0) begin
          chk("unexpected_validB", 24'(qB.size()), 24'h1);
        end else begin
          e = qB.pop_front();
          chk("resultB", {20'h0, resB}, e.res);
          chk("overflowB", 24'(ovB), 24'(e.ovf));
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sig = ~sig;
      #1;
      chk("rst_cnt_reset", 24'(crA), 24'h1);
      chk("rst_enable", 24'(enA), 24'h0);
      chk("rst_gate", 24'(gaA), 24'h0);
      chk("rst_valid", 24'({rvA, rvB}), 24'h0);
      chk("rst_resultA", resA, 24'h0);
      chk("rst_ovf", 24'({ovA, ovB}), 24'h0);
      chk("rst_resultB", {20'h0, resB}, 24'h0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    last_ref = cyc;
  endtask

  task automatic run_period(input pat_t p, input int s, input logic [23:0] e6,
                            input logic [3:0] e1, input logic o1,
                            input int rst_at);
    qA.push_back('{disp6(e6), 1'b0});
    qB.push_back('{{20'h0, e1}, o1});
    for (int m = 0; m < PER; m++) begin
      sig = lvl(p, s, m);
      if (m == rst_at) begin
        void'(qA.pop_back());
        void'(qB.pop_back());
        do_reset();
        return;
      end
      if (m == 0 || m == 1 || m == 100 || m == 101) begin
        #1;
        chk("cnt_reset_phase", 24'(crA), 24'(m == 0));
        chk("gate_active_phase", 24'(gaA), 24'(m == 1 || m == 100));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sig   = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    run_period(P_SQ,    0,  24'h000025, 4'h5, 1'b1, -1);
    run_period(P_SQ,    0,  24'h000025, 4'h5, 1'b1, -1);
    run_period(P_LOW,   0,  24'h000000, 4'h0, 1'b0, -1);
    run_period(P_LATE,  0,  24'h000000, 4'h0, 1'b0, -1);
    run_period(P_HIGH,  0,  24'h000000, 4'h0, 1'b0, -1);
    run_period(P_PULSE, 99, 24'h000000, 4'h0, 1'b0, -1);
    run_period(P_PULSE, 98, 24'h000001, 4'h1, 1'b0, -1);
    run_period(P_TRI,   0,  24'h000003, 4'h3, 1'b0, -1);
    run_period(P_SQ,    0,  24'h000025, 4'h5, 1'b1, -1);
    run_period(P_SQ,    0,  24'h000025, 4'h5, 1'b1, 50);
    run_period(P_SQ,    0,  24'h000025, 4'h5, 1'b1, -1);
    run_period(P_LOW,   0,  24'h000000, 4'h0, 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("queueA_drained", 24'(qA.size()), 24'h0);
    chk("queueB_drained", 24'(qB.size()), 24'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
